alu_secuenciador: RTL and testbench

Sequencer that sits in front of the ALU result multiplexer and its operator units. Accepts one operation per valid/ready handshake, registers operands and the 4-bit operation code that drive the ALU, captures the selected result, and returns it with flags over a second valid/ready handshake. Division and modulo are executed by an internal iterative divider instead of the combinational path, so the block owns all multi-cycle sequencing of the datapath.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_secuenciador_if.sv | 25 ++
 rtl/divisor_iterativo.sv | 48 ++++
 rtl/alu_secuenciador.sv | 71 +++++++
 tb/tb_alu_secuenciador.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, sequencer states and code classification helpers
package alu_pkg;
  localparam logic [3:0] OP_SUMA  = 4'd0;
  localparam logic [3:0] OP_RESTA = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MOD   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  typedef enum logic [1:0] {INACTIVO, EJECUTA, DIVIDE, ENTREGA} estado_t;
  function automatic logic es_division(input logic [3:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
  function automatic logic es_indefinida(input logic [3:0] op);
    return op > OP_SHR;
  endfunction
endpackage

// File: rtl/alu_secuenciador_if.sv
// alu_secuenciador_if: request, ALU-facing and response signals of the sequencer
interface alu_secuenciador_if #(parameter int ancho = 3) ();
  logic             entrada_valida;
  logic             entrada_lista;
  logic [ancho:0]   operandoA;
  logic [ancho:0]   operandoB;
  logic [3:0]       operacion;
  logic [ancho:0]   alu_a;
  logic [ancho:0]   alu_b;
  logic [3:0]       seleccion;
  logic [ancho:0]   resultado_alu;
  logic             salida_valida;
  logic             salida_lista;
  logic [ancho:0]   resultado;
  logic             cero;
  logic             error;
  modport master (
    output entrada_valida, operandoA, operandoB, operacion, resultado_alu, salida_lista,
    input  entrada_lista, alu_a, alu_b, seleccion, salida_valida, resultado, cero, error
  );
  modport slave (
    input  entrada_valida, operandoA, operandoB, operacion, resultado_alu, salida_lista,
    output entrada_lista, alu_a, alu_b, seleccion, salida_valida, resultado, cero, error
  );
endinterface

// File: rtl/divisor_iterativo.sv
// divisor_iterativo: unsigned restoring divider, one quotient bit per cycle
module divisor_iterativo #(parameter int ancho = 3) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inicio,
  input  logic [ancho:0] dividendo,
  input  logic [ancho:0] divisor,
  output logic [ancho:0] cociente,
  output logic [ancho:0] residuo,
  output logic           listo
);
  localparam int W  = ancho + 1;
  localparam int CW = $clog2(W + 1);
  logic [ancho:0] res_q, coc_q, div_q, res_d, coc_d;
  logic [CW-1:0]  cnt_q;
  logic           listo_q;
  logic [W:0]     parcial, resta;
  // coc_q doubles as the dividend shift register; quotient bits enter at the bottom
  always_comb begin
    parcial = {res_q, coc_q[ancho]};
    resta   = parcial - {1'b0, div_q};
    res_d   = resta[W] ? parcial[ancho:0] : resta[ancho:0];
    coc_d   = {coc_q[ancho-1:0], ~resta[W]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      res_q   <= '0;
      coc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      listo_q <= 1'b0;
    end else begin
      listo_q <= cnt_q == CW'(1);
      if (inicio) begin
        res_q <= '0;
        coc_q <= dividendo;
        div_q <= divisor;
        cnt_q <= CW'(W);
      end else if (cnt_q != '0) begin
        res_q <= res_d;
        coc_q <= coc_d;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  assign cociente = coc_q;
  assign residuo  = res_q;
  assign listo    = listo_q;
endmodule

// File: rtl/alu_secuenciador.sv
// alu_secuenciador: request/response sequencer around the ALU mux with an iterative divider
module alu_secuenciador import alu_pkg::*; #(parameter int ancho = 3) (
  input logic               clk,
  input logic               reset,
  alu_secuenciador_if.slave bus
);
  estado_t        estado_q;
  logic [ancho:0] a_q, b_q, res_q, cociente, residuo, div_res;
  logic [3:0]     sel_q;
  logic           lista_q, valida_q, cero_q, error_q, err_pend_q, listo, inicio, err_d;
  always_comb begin
    inicio  = estado_q == INACTIVO && bus.entrada_valida && es_division(bus.operacion) && bus.operandoB != '0;
    err_d   = es_indefinida(bus.operacion) || (es_division(bus.operacion) && bus.operandoB == '0);
    div_res = sel_q == OP_DIV ? cociente : residuo;
  end
  divisor_iterativo #(.ancho(ancho)) u_div (
    .clk, .reset, .inicio,
    .dividendo(bus.operandoA), .divisor(bus.operandoB),
    .cociente, .residuo, .listo
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      estado_q   <= INACTIVO;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      res_q      <= '0;
      cero_q     <= 1'b0;
      error_q    <= 1'b0;
      err_pend_q <= 1'b0;
      lista_q    <= 1'b1;
      valida_q   <= 1'b0;
    end else
      case (estado_q)
        INACTIVO: if (bus.entrada_valida) begin
          a_q        <= bus.operandoA;
          b_q        <= bus.operandoB;
          sel_q      <= bus.operacion;
          err_pend_q <= err_d;
          lista_q    <= 1'b0;
          estado_q   <= inicio ? DIVIDE : EJECUTA;
        end
        EJECUTA: begin
          res_q    <= err_pend_q ? '0 : bus.resultado_alu;
          cero_q   <= err_pend_q || bus.resultado_alu == '0;
          error_q  <= err_pend_q;
          valida_q <= 1'b1;
          estado_q <= ENTREGA;
        end
        DIVIDE: if (listo) begin
          res_q    <= div_res;
          cero_q   <= div_res == '0;
          error_q  <= 1'b0;
          valida_q <= 1'b1;
          estado_q <= ENTREGA;
        end
        ENTREGA: if (bus.salida_lista) begin
          valida_q <= 1'b0;
          lista_q  <= 1'b1;
          estado_q <= INACTIVO;
        end
      endcase
  assign bus.entrada_lista = lista_q;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;
  assign bus.seleccion     = sel_q;
  assign bus.salida_valida = valida_q;
  assign bus.resultado     = res_q;
  assign bus.cero          = cero_q;
  assign bus.error         = error_q;
endmodule

// File: tb/tb_alu_secuenciador.sv
// tb_alu_secuenciador: scoreboard bench with an external ALU model and randomized operations
module tb_alu_secuenciador;
  import alu_pkg::*;
  localparam int W = 4;
  typedef struct {
    logic [3:0] a, b, op, res;
    logic       cero, err;
    int         n, lat;
  } item_t;
  logic clk = 0, reset = 0;
  int   cyc = 0, total = 0, passed = 0;
  int   n1, n2, c;
  bit   rand_bp = 0, force_low = 0, in_out = 0;
  logic [3:0] held;
  logic held_c, held_e;
  item_t q[$];

  alu_secuenciador_if #(.ancho(3)) bus();
  alu_secuenciador #(.ancho(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External result multiplexer; codes it does not implement return a marker value
  function automatic logic [3:0] alu_mux(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    case (sel)
      OP_SUMA:  return a + b;
      OP_RESTA: return a - b;
      OP_MULT:  return a * b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_SHL:   return a << b;
      OP_SHR:   return a >> b;
      default:  return 4'hA;
    endcase
  endfunction
  assign bus.resultado_alu = alu_mux(bus.alu_a, bus.alu_b, bus.seleccion);

  function automatic item_t modelo(input int a, input int b, input int op);
    item_t it;
    int r;
    r = 0;
    it.err = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: if (b == 0) it.err = 1; else r = a / b;
      4: if (b == 0) it.err = 1; else r = a % b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = a << b;
      9: r = a >> b;
      default: it.err = 1;
    endcase
    r = r & 15;
    it.a = a[3:0];
    it.b = b[3:0];
    it.op = op[3:0];
    it.res = r[3:0];
    it.cero = r == 0;
    it.lat = ((op == 3 || op == 4) && b != 0) ? W + 1 : 1;
    it.n = 0;
    return it;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_entrada_lista"}, bus.entrada_lista, 1);
    chk({nm, "_salida_valida"}, bus.salida_valida, 0);
    chk({nm, "_alu_a"}, bus.alu_a, 0);
    chk({nm, "_alu_b"}, bus.alu_b, 0);
    chk({nm, "_seleccion"}, bus.seleccion, 0);
    chk({nm, "_resultado"}, bus.resultado, 0);
    chk({nm, "_cero"}, bus.cero, 0);
    chk({nm, "_error"}, bus.error, 0);
  endtask

  task automatic send(input int a, input int b, input int op, output int n);
    item_t it;
    int t;
    it = modelo(a, b, op);
    t = 0;
    n = -1;
    bus.entrada_valida = 1;
    bus.operandoA = a[3:0];
    bus.operandoB = b[3:0];
    bus.operacion = op[3:0];
    while (!bus.entrada_lista && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t == 200) begin
      chk("accept_timeout", 0, 1);
      bus.entrada_valida = 0;
      return;
    end
    it.n = cyc + 1;
    n = it.n;
    q.push_back(it);
    @(posedge clk);
    #1 bus.entrada_valida = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  // Consumer ready changes just after the active edge so the monitor sees a settled value
  always begin
    bus.salida_lista = force_low ? 1'b0 : rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    @(posedge clk);
    #1;
  end

  always @(negedge clk)
    if (reset) in_out = 0;
    else begin
      if (q.size() > 0 && cyc >= q[0].n) begin
        chk("entrada_lista_ocupado", bus.entrada_lista, 0);
        chk("alu_a", bus.alu_a, q[0].a);
        chk("alu_b", bus.alu_b, q[0].b);
        chk("seleccion", bus.seleccion, q[0].op);
      end
      if (bus.salida_valida) begin
        if (q.size() == 0) chk("salida_inesperada", 1, 0);
        else begin
          if (!in_out) begin
            chk("latencia", cyc - q[0].n, q[0].lat);
            held = bus.resultado;
            held_c = bus.cero;
            held_e = bus.error;
            in_out = 1;
          end else begin
            chk("resultado_estable", bus.resultado, held);
            chk("cero_estable", bus.cero, held_c);
            chk("error_estable", bus.error, held_e);
          end
          if (bus.salida_lista) begin
            chk("resultado", bus.resultado, q[0].res);
            chk("cero", bus.cero, q[0].cero);
            chk("error", bus.error, q[0].err);
            void'(q.pop_front());
            in_out = 0;
          end
        end
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.entrada_valida = 0;
    bus.operandoA = 0;
    bus.operandoB = 0;
    bus.operacion = 0;
    #1 reset = 1;
    #1 chk_reset("reset_inicial");
    @(negedge clk);
    reset = 0;
    send(3, 4, 0, n1);
    send(13, 3, 3, n1);
    send(13, 3, 4, n1);
    send(9, 0, 3, n1);
    send(7, 2, 12, n1);
    send(5, 5, 7, n1);
    send(1, 2, 6, n1);
    send(4, 4, 5, n2);
    chk("throughput", n2 - n1, 3);
    drain();
    force_low = 1;
    @(posedge clk);
    #2;
    send(2, 1, 1, n1);
    bus.entrada_valida = 1;
    bus.operandoA = 4'd6;
    bus.operandoB = 4'd3;
    bus.operacion = OP_AND;
    c = 0;
    while (!bus.salida_valida && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("espera_salida_valida", bus.salida_valida, 1);
    repeat (6) @(negedge clk);
    force_low = 0;
    c = cyc;
    send(6, 3, 5, n2);
    chk("aceptacion_tras_entrega", n2, c + 3);
    drain();
    send(15, 2, 3, n1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
    #1 chk_reset("reset_en_division");
    q.delete();
    @(negedge clk);
    reset = 0;
    send(6, 2, 3, n1);
    drain();
    rand_bp = 1;
    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 15), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15), $urandom_range(0, 15), n1);
    drain();
    rand_bp = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
